// File: rtl/hilo_mult_div_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply/divide unit.
interface hilo_mult_div_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] WrData;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output Start, Op, A, B, HiWrite, LoWrite, WrData,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B, HiWrite, LoWrite, WrData,
        output Busy, Done, DivByZero, Hi, Lo
    );
endinterface

// File: rtl/hilo_mult_div.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO (shift-add multiply, restoring divide).
// Optional HILO_MULT_EARLY_TERM_EN: multiply stops once the remaining multiplier is zero.
module hilo_mult_div (
    input  logic            Clk,
    input  logic            Reset_n,
    hilo_mult_div_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DLEN  = 2 * XLEN;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_div_q, op_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    // MUL: running product. DIV: {remainder, dividend/quotient}. Div-by-zero: {A, all ones}.
    logic [DLEN-1:0]  acc_q, acc_d;
    logic [DLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;

    logic             sgn_op;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN:0]    rem_sh, rem_diff;
    logic             q_bit;
    logic [DLEN-1:0]  prod_fix;
    logic             last_iter;

    // Operand magnitudes and one restoring-divide step.
    always_comb begin
        sgn_op   = ~bus.Op[0];
        abs_a    = (sgn_op && bus.A[XLEN-1]) ? (~bus.A + XLEN'(1)) : bus.A;
        abs_b    = (sgn_op && bus.B[XLEN-1]) ? (~bus.B + XLEN'(1)) : bus.B;
        rem_sh   = {acc_q[DLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, mcand_q[XLEN-1:0]};
        q_bit    = ~rem_diff[XLEN];
        prod_fix = neg_res_q ? (~acc_q + DLEN'(1)) : acc_q;
        last_iter = (cnt_q == CNT_W'(ITER - 1));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        busy_d     = busy_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    // Start takes priority over a same-cycle MTHI/MTLO
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    op_div_d = bus.Op[1];
                    if (bus.Op[1] && (bus.B == '0)) begin
                        state_d    = S_FIX;
                        dbz_pend_d = 1'b1;
                        neg_res_d  = 1'b0;
                        neg_rem_d  = 1'b0;
                        acc_d      = {bus.A, {XLEN{1'b1}}};
                    end else if (bus.Op[1]) begin
                        state_d    = S_DIV;
                        dbz_pend_d = 1'b0;
                        neg_res_d  = sgn_op & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
                        neg_rem_d  = sgn_op & bus.A[XLEN-1];
                        acc_d      = {{XLEN{1'b0}}, abs_a};
                        mcand_d    = {{XLEN{1'b0}}, abs_b};
                    end else begin
                        state_d    = S_MUL;
                        dbz_pend_d = 1'b0;
                        neg_res_d  = sgn_op & (bus.A[XLEN-1] ^ bus.B[XLEN-1]);
                        neg_rem_d  = 1'b0;
                        acc_d      = '0;
                        mcand_d    = {{XLEN{1'b0}}, abs_a};
                        mplier_d   = abs_b;
                    end
                end else begin
                    if (bus.HiWrite) hi_d = bus.WrData;
                    if (bus.LoWrite) lo_d = bus.WrData;
                end
            end

            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef HILO_MULT_EARLY_TERM_EN
                if (last_iter || (mplier_q[XLEN-1:1] == '0)) state_d = S_FIX;
`else
                if (last_iter) state_d = S_FIX;
`endif
            end

            S_DIV: begin
                acc_d = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                         acc_q[XLEN-2:0], q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) state_d = S_FIX;
            end

            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (dbz_pend_q) begin
                    dbz_d = 1'b1;
                    hi_d  = acc_q[DLEN-1:XLEN];
                    lo_d  = acc_q[XLEN-1:0];
                end else if (op_div_q) begin
                    lo_d = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
                    hi_d = neg_rem_q ? (~acc_q[DLEN-1:XLEN] + XLEN'(1)) : acc_q[DLEN-1:XLEN];
                end else begin
                    hi_d = prod_fix[DLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_hilo_mult_div.sv
// Directed-vector bench for hilo_mult_div: table of ops plus busy/reset/MTHI corner sequences.
module tb_hilo_mult_div;
    logic Clk;
    logic Reset_n;
    hilo_mult_div_if bus ();

    hilo_mult_div dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef HILO_MULT_EARLY_TERM_EN
        logic [31:0] ab;
        int msb;
        if (op[1]) return (b == 32'd0) ? 1 : 33;
        ab  = (!op[0] && b[31]) ? (~b + 32'd1) : b;
        msb = 0;
        for (int i = 0; i < 32; i++) if (ab[i]) msb = i;
        return msb + 2;
`else
        if (op[1] && b == 32'd0) return 1;
        return 33;
`endif
    endfunction

    // Called 1 time unit after an edge; leaves us 1 unit after E0.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
    endtask

    // Advances until Done, with a bounded cycle budget; n counts edges since E0.
    task automatic wait_done(input int n0, output int n, output logic seen);
        n = n0;
        while (!bus.Done && n < 45) begin
            @(posedge Clk); #1;
            n++;
        end
        seen = bus.Done;
    endtask

    initial begin
        int n;
        logic seen;
        int done_cnt;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{2'b10, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
        vecs[11] = '{2'b01, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 1'b0};
        vecs[12] = '{2'b01, 32'd5,         32'd3,         32'd0,         32'd15,        1'b0};
        vecs[13] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};

        bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WrData = '0;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;

        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_dbz",  64'(bus.DivByZero), 64'd0);
        check("reset_hi",   64'(bus.Hi), 64'd0);
        check("reset_lo",   64'(bus.Lo), 64'd0);

        // Table-driven operations
        for (int i = 0; i < NVEC; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy_e0", i), 64'(bus.Busy), 64'd1);
            wait_done(0, n, seen);
            check($sformatf("v%0d_done_seen", i), 64'(seen), 64'd1);
            check($sformatf("v%0d_latency", i), 64'(n), 64'(exp_lat(vecs[i].op, vecs[i].b)));
            check($sformatf("v%0d_hi", i), 64'(bus.Hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(bus.Lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dbz", i), 64'(bus.DivByZero), 64'(vecs[i].dbz));
            check($sformatf("v%0d_busy_done", i), 64'(bus.Busy), 64'd0);
            @(posedge Clk); #1;
            check($sformatf("v%0d_done_pulse", i), 64'(bus.Done), 64'd0);
            check($sformatf("v%0d_hi_hold", i), 64'(bus.Hi), 64'(vecs[i].hi));
        end

        // Idle MTHI / MTLO
        bus.HiWrite = 1'b1; bus.WrData = 32'hA5A5_A5A5;
        @(posedge Clk); #1;
        bus.HiWrite = 1'b0;
        check("mthi", 64'(bus.Hi), 64'hA5A5_A5A5);
        bus.LoWrite = 1'b1; bus.WrData = 32'h0F0F_0F0F;
        @(posedge Clk); #1;
        bus.LoWrite = 1'b0;
        check("mtlo", 64'(bus.Lo), 64'h0F0F_0F0F);

        // Start with same-cycle MTHI: write dropped, Hi holds until FIX
        bus.HiWrite = 1'b1; bus.WrData = 32'h5555_5555;
        start_op(2'b11, 32'd100, 32'd7);
        bus.HiWrite = 1'b0;
        check("start_wins_hi", 64'(bus.Hi), 64'hA5A5_A5A5);
        wait_done(0, n, seen);
        check("start_wins_lat", 64'(n), 64'd33);
        check("start_wins_res", {32'(bus.Hi), 32'(bus.Lo)}, {32'd2, 32'd14});

        // Start in the Done cycle is accepted
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        check("done_cycle_start_busy", 64'(bus.Busy), 64'd1);
        wait_done(0, n, seen);
        check("done_cycle_start_lat", 64'(n), 64'(exp_lat(2'b00, 32'd7)));
        check("done_cycle_start_res", {32'(bus.Hi), 32'(bus.Lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge Clk); #1;

        // Start at E5 and MTLO at E6 while busy are ignored
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(posedge Clk);
        #1;
        bus.Start = 1'b1; bus.Op = 2'b11; bus.A = 32'd5; bus.B = 32'd0;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        bus.LoWrite = 1'b1; bus.WrData = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        bus.LoWrite = 1'b0;
        check("busy_mtlo_ignored", 64'(bus.Lo), 64'hFFFF_FFFF_FFFF_FFEB & 64'hFFFF_FFFF);
        check("busy_still", 64'(bus.Busy), 64'd1);
        check("busy_no_dbz_done", 64'(bus.Done), 64'd0);
        wait_done(6, n, seen);
        check("busy_lat", 64'(n), 64'd33);
        check("busy_res", {32'(bus.Hi), 32'(bus.Lo)}, 64'hFFFF_FFFE_0000_0001);
        check("busy_res_dbz", 64'(bus.DivByZero), 64'd0);
        @(posedge Clk); #1;

        // Async reset at E10 aborts the operation
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.Busy), 64'd0);
        check("rst_mid_hi",   64'(bus.Hi), 64'd0);
        check("rst_mid_lo",   64'(bus.Lo), 64'd0);
        check("rst_mid_done", 64'(bus.Done), 64'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk); #1;
            if (bus.Done) done_cnt++;
        end
        check("rst_no_done", 64'(done_cnt), 64'd0);
        check("rst_idle_busy", 64'(bus.Busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
